uart_rx: RTL and testbench

Serial receiver for the board's UART link, the receive-side counterpart of the existing UART transmitter, with identical frame format and parameters. It oversamples `i_uart_rx` with the system clock, recovers start, data (LSB first), optional parity and stop bits, and delivers each byte to the frame-buffer and command logic as a one-cycle valid pulse. Parity and framing errors are flagged per frame.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, baud period and parity helpers
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    function automatic int calc_cycle(input int clk_fre, input int baud_rate);
        return (clk_fre * 1000000) / baud_rate;
    endfunction

    // parity_type 1: bit equals XOR of data; 0: bit equals inverted XOR
    function automatic logic parity_expect(input logic data_xor, input logic parity_type);
        return parity_type ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop line synchronizer with falling-edge detect (flops reset high)
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_rx_s;
    logic r_rx_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_rx_s <= 1'b1;
            r_rx_d <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_rx_s <= r_meta;
            r_rx_d <= r_rx_s;
        end
    end

    assign o_rx_s = r_rx_s;
    assign o_fall = r_rx_d & ~r_rx_s;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 bit voting
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE     = 50,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_ON   = 0,
    parameter int PARITY_TYPE = 0,
    parameter int BAUD_RATE   = 9600
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst,
    input  logic                  i_uart_rx,
    output logic [DATA_WIDTH-1:0] o_data_rx,
    output logic                  o_data_valid,
    output logic                  o_parity_err,
    output logic                  o_frame_err
);

    localparam int          CYCLE     = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam logic [15:0] C_BIT_END = 16'(CYCLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] C_SAMPLE  = 16'(CYCLE / 2);
`else
    localparam logic [15:0] C_SAMPLE  = 16'(CYCLE / 2 - 1);
`endif

    logic                  w_rx_s;
    logic                  w_fall;
    logic                  w_bit;
    logic                  w_sample;
    logic                  w_bit_end;

    logic [2:0]            r_state;
    logic [15:0]           r_baud_cnt;
    logic [3:0]            r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_acc;
    logic                  r_par_err;
    logic [DATA_WIDTH-1:0] r_data_rx;
    logic                  r_data_valid;
    logic                  r_parity_err;
    logic                  r_frame_err;

    uart_rx_sync u_sync (
        .i_clk  (i_clk_sys),
        .i_rst  (i_rst),
        .i_rx   (i_uart_rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two earlier samples are held; the third is the live rx_s at the decision count
    logic [1:0] r_maj;

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_maj <= 2'b11;
        end else if (r_baud_cnt == C_SAMPLE - 16'd2 || r_baud_cnt == C_SAMPLE - 16'd1) begin
            r_maj <= {r_maj[0], w_rx_s};
        end
    end

    assign w_bit = (r_maj[1] & r_maj[0]) | (r_maj[1] & w_rx_s) | (r_maj[0] & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    assign w_sample  = (r_baud_cnt == C_SAMPLE);
    assign w_bit_end = (r_baud_cnt == C_BIT_END);

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_baud_cnt <= 16'd0;
        end else if (r_state == ST_IDLE || r_state == ST_WAIT_HIGH || w_bit_end) begin
            r_baud_cnt <= 16'd0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_par_err    <= 1'b0;
            r_data_rx    <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= 4'd0;
                    r_par_acc <= 1'b0;
                    r_par_err <= 1'b0;
                    if (w_fall) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_sample && w_bit) begin
                        r_state <= ST_IDLE;
                    end else if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= 4'd0;
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                        r_par_acc <= r_par_acc ^ w_bit;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else if (w_bit_end && r_bit_cnt == 4'(DATA_WIDTH)) begin
                        r_state <= (PARITY_ON != 0) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (w_sample) begin
                        if (w_bit != parity_expect(r_par_acc, PARITY_TYPE != 0)) begin
                            r_par_err <= 1'b1;
                        end
                    end else if (w_bit_end) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leave at mid-bit so a start edge half a bit later is not missed
                    if (w_sample) begin
                        if (w_bit) begin
                            r_state      <= ST_IDLE;
                            r_data_rx    <= r_shift;
                            r_data_valid <= 1'b1;
                            r_parity_err <= r_par_err;
                        end else begin
                            r_state     <= ST_WAIT_HIGH;
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_data_rx    = r_data_rx;
    assign o_data_valid = r_data_valid;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (no-parity and odd/even-parity instances)
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FRE   = 1;
    localparam int BAUD_RATE = 62500;
    localparam int CYC       = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;

    int checks = 0;
    int failures = 0;

    int         cycle_cnt = 0;
    int         n_valid_a = 0, n_ferr_a = 0, n_valid_b = 0;
    logic [7:0] log_data_a [64];
    int         log_time_a [64];
    logic [7:0] last_data_b = 8'h00;
    logic       last_perr_b = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.CLK_FRE(CLK_FRE), .DATA_WIDTH(8), .PARITY_ON(0), .PARITY_TYPE(0), .BAUD_RATE(BAUD_RATE)) dut_a (
        .i_clk_sys(clk), .i_rst(rst), .i_uart_rx(rx_a),
        .o_data_rx(data_a), .o_data_valid(valid_a), .o_parity_err(perr_a), .o_frame_err(ferr_a)
    );

    uart_rx #(.CLK_FRE(CLK_FRE), .DATA_WIDTH(8), .PARITY_ON(1), .PARITY_TYPE(1), .BAUD_RATE(BAUD_RATE)) dut_b (
        .i_clk_sys(clk), .i_rst(rst), .i_uart_rx(rx_b),
        .o_data_rx(data_b), .o_data_valid(valid_b), .o_parity_err(perr_b), .o_frame_err(ferr_b)
    );

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(negedge clk) begin
        if (valid_a) begin
            if (n_valid_a < 64) begin
                log_data_a[n_valid_a] = data_a;
                log_time_a[n_valid_a] = cycle_cnt;
            end
            n_valid_a = n_valid_a + 1;
        end
        if (ferr_a) n_ferr_a = n_ferr_a + 1;
        if (valid_b) begin
            last_data_b = data_b;
            last_perr_b = perr_b;
            n_valid_b   = n_valid_b + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit sel_b, input logic v);
        if (sel_b) rx_b = v;
        else rx_a = v;
        repeat (CYC) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel_b, input logic [7:0] d, input bit with_par,
                              input logic pbit, input logic stop_v);
        drive_bit(sel_b, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel_b, d[i]);
        if (with_par) drive_bit(sel_b, pbit);
        drive_bit(sel_b, stop_v);
    endtask

    int         va0, fa0, vb0, idx, gap;
    logic [7:0] c3;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data_a}, 32'h0);
        check("rst_valid", {31'd0, valid_a}, 32'h0);
        check("rst_perr", {31'd0, perr_a}, 32'h0);
        check("rst_ferr", {31'd0, ferr_a}, 32'h0);
        check("rst_valid_b", {31'd0, valid_b}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        va0 = n_valid_a; fa0 = n_ferr_a;
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        repeat (2 * CYC) @(negedge clk);
        check("a5_count", n_valid_a - va0, 1);
        check("a5_data", {24'd0, log_data_a[va0]}, 32'hA5);
        check("a5_ferr", n_ferr_a - fa0, 0);

        va0 = n_valid_a; idx = n_valid_a;
        send_frame(0, 8'h00, 0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 0, 1'b0, 1'b1);
        repeat (2 * CYC) @(negedge clk);
        check("b2b_count", n_valid_a - va0, 2);
        check("b2b_data0", {24'd0, log_data_a[idx]}, 32'h00);
        check("b2b_data1", {24'd0, log_data_a[idx+1]}, 32'hFF);
        gap = log_time_a[idx+1] - log_time_a[idx];
        check("b2b_gap_in_range", {31'd0, (gap >= 10*CYC-2) && (gap <= 10*CYC+2)}, 32'h1);

        vb0 = n_valid_b;
        send_frame(1, 8'h3C, 1, 1'b1, 1'b1);
        repeat (2 * CYC) @(negedge clk);
        check("par_bad_count", n_valid_b - vb0, 1);
        check("par_bad_data", {24'd0, last_data_b}, 32'h3C);
        check("par_bad_perr", {31'd0, last_perr_b}, 32'h1);
        vb0 = n_valid_b;
        send_frame(1, 8'h3C, 1, 1'b0, 1'b1);
        repeat (2 * CYC) @(negedge clk);
        check("par_ok_count", n_valid_b - vb0, 1);
        check("par_ok_perr", {31'd0, last_perr_b}, 32'h0);

        va0 = n_valid_a; fa0 = n_ferr_a;
        send_frame(0, 8'h33, 0, 1'b0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        check("ferr_count", n_ferr_a - fa0, 1);
        check("ferr_no_valid", n_valid_a - va0, 0);
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
        repeat (2 * CYC) @(negedge clk);
        check("after_ferr_count", n_valid_a - va0, 1);
        check("after_ferr_data", {24'd0, log_data_a[va0]}, 32'h5A);
        check("after_ferr_no_ferr", n_ferr_a - fa0, 1);

        va0 = n_valid_a; fa0 = n_ferr_a;
        rx_a = 1'b0;
        repeat (6) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * CYC) @(negedge clk);
        check("glitch_no_valid", n_valid_a - va0, 0);
        check("glitch_no_ferr", n_ferr_a - fa0, 0);
        check("glitch_idle", {29'd0, dut_a.r_state}, {29'd0, ST_IDLE});

        va0 = n_valid_a;
        c3 = 8'hC3;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, c3[i]);
        rx_a = c3[4];
        repeat (CYC / 2) @(negedge clk);
        rst = 1'b1;
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_data", {24'd0, data_a}, 32'h0);
        check("midrst_valid", {31'd0, valid_a}, 32'h0);
        check("midrst_perr_ferr", {30'd0, perr_a, ferr_a}, 32'h0);
        rst = 1'b0;
        repeat (12 * CYC) @(negedge clk);
        check("midrst_no_valid", n_valid_a - va0, 0);
        send_frame(0, 8'h81, 0, 1'b0, 1'b1);
        repeat (2 * CYC) @(negedge clk);
        check("after_rst_count", n_valid_a - va0, 1);
        check("after_rst_data", {24'd0, log_data_a[va0]}, 32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
